// File: rtl/floor_display_driver.sv
// floor_display_driver: time-multiplexed 4-digit common-anode seven-segment driver.
// Shows the two floor digits from the elevator FSM, an 'E' on the leftmost digit
// during emergency, and blinks the whole display while emergency is active.
// Digit codes are snapshotted once per frame so a frame never mixes old and new values.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the second digit when it is 0).
module floor_display_driver #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Disp_1,
    input  logic [3:0] Disp_2,
    input  logic       emerg,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]    GLYPH_E = 7'h79;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_t;
    typedef enum logic {PH_ON, PH_OFF} phase_t;

    slot_t         slot_q, slot_d;
    phase_t        phase_q, phase_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [3:0]    snap1_q, snap1_d, snap2_q, snap2_d;
    logic          sync1_q, sync1_d, sync_q, sync_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          ftick_q, ftick_d;
    logic [3:0]    an_n;
    logic [6:0]    glyph_n;

    // Active-high gfedcba pattern for a hex digit code
    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Next-state logic: scan timing, frame snapshot, emergency sync, blink, output decode
    always_comb begin
        rcnt_d  = rcnt_q + 1'b1;
        slot_d  = slot_q;
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        ftick_d = 1'b0;
        if (rcnt_q == R_LAST) begin
            rcnt_d = '0;
            case (slot_q)
                DIG0: slot_d = DIG1;
                DIG1: slot_d = DIG2;
                DIG2: slot_d = DIG3;
                default: begin
                    slot_d  = DIG0;
                    snap1_d = Disp_1;
                    snap2_d = Disp_2;
                    ftick_d = 1'b1;
                end
            endcase
        end

        sync1_d = emerg;
        sync_d  = sync1_q;

        if (sync_q) begin
            if (bcnt_q == B_LAST) begin
                bcnt_d  = '0;
                phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                phase_d = phase_q;
            end
        end else begin
            bcnt_d  = '0;
            phase_d = PH_ON;
        end

        an_n    = 4'b1111;
        glyph_n = 7'h00;
        case (slot_q)
            DIG0: begin
                an_n    = 4'b1110;
                glyph_n = glyph(snap1_q);
            end
            DIG1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (snap2_q != 4'd0) begin
                    an_n    = 4'b1101;
                    glyph_n = glyph(snap2_q);
                end
`else
                an_n    = 4'b1101;
                glyph_n = glyph(snap2_q);
`endif
            end
            DIG2: ;
            default: begin
                if (sync_q) begin
                    an_n    = 4'b0111;
                    glyph_n = GLYPH_E;
                end
            end
        endcase
        // Gating on sync_q (not just phase) lets the display return as soon as
        // emergency clears, without waiting for the phase register to reset
        if (sync_q && (phase_q == PH_OFF)) begin
            an_n    = 4'b1111;
            glyph_n = 7'h00;
        end
        an_d  = an_n;
        seg_d = SEG_ACTIVE_LOW ? ~glyph_n : glyph_n;
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q  <= DIG0;
            phase_q <= PH_ON;
            rcnt_q  <= '0;
            bcnt_q  <= '0;
            snap1_q <= '0;
            snap2_q <= '0;
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            ftick_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            phase_q <= phase_d;
            rcnt_q  <= rcnt_d;
            bcnt_q  <= bcnt_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            sync1_q <= sync1_d;
            sync_q  <= sync_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            ftick_q <= ftick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_floor_display_driver.sv
// tb_floor_display_driver: randomized stimulus checked every cycle against a
// cycle-indexed reference model built from input history arrays.
module tb_floor_display_driver;

    localparam int R    = 4;
    localparam int B    = 8;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Disp_1, Disp_2;
    logic       emerg;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;

    logic       e_h  [0:MAXC];
    logic [3:0] d1_h [0:MAXC];
    logic [3:0] d2_h [0:MAXC];

    logic [6:0] gtab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    floor_display_driver #(
        .REFRESH_DIV    (R),
        .BLINK_DIV      (B),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Disp_1     (Disp_1),
        .Disp_2     (Disp_2),
        .emerg      (emerg),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d got=%0h exp=%0h", tag, k, got, exp);
    endtask

    // Synchronised emergency level held after edge j (two edges of latency)
    function automatic logic sync_after(input int j);
        return (j >= 2) ? e_h[j-1] : 1'b0;
    endfunction

    // Expected outputs right after edge n, counting edges from reset release
    task automatic model(input int n, output logic [3:0] an_e, output logic [6:0] seg_e,
                         output logic ft_e);
        int t, slot, fs, run;
        logic [3:0] s1, s2;
        logic [6:0] g;
        logic sy, off;
        t    = n - 1;
        slot = (t / R) % 4;
        fs   = (t / (4*R)) * (4*R);
        s1   = (fs >= 4*R) ? d1_h[fs] : 4'd0;
        s2   = (fs >= 4*R) ? d2_h[fs] : 4'd0;
        sy   = sync_after(t);
        run  = 0;
        for (int j = t; j >= 1; j--) begin
            if (sync_after(j-1)) run++;
            else break;
        end
        off  = sy && (((run / B) % 2) == 1);
        an_e = 4'b1111;
        g    = 7'h00;
        case (slot)
            0: begin an_e = 4'b1110; g = gtab[s1]; end
            1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (s2 != 0) begin an_e = 4'b1101; g = gtab[s2]; end
`else
                an_e = 4'b1101; g = gtab[s2];
`endif
            end
            3: if (sy) begin an_e = 4'b0111; g = 7'h79; end
            default: ;
        endcase
        if (off) begin an_e = 4'b1111; g = 7'h00; end
        seg_e = ~g;
        ft_e  = (n % (4*R)) == 0;
    endtask

    // Record inputs sampled at the next edge, advance one clock, compare
    task automatic step();
        logic [3:0] ae;
        logic [6:0] se;
        logic fe;
        k++;
        e_h[k]  = emerg;
        d1_h[k] = Disp_1;
        d2_h[k] = Disp_2;
        @(posedge clk);
        #1;
        model(k, ae, se, fe);
        check("an", 32'(an), 32'(ae));
        check("seg", 32'(seg), 32'(se));
        check("dp", 32'(dp), 32'd1);
        check("frame_tick", 32'(frame_tick), 32'(fe));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'd1);
        check({tag, "_ft"}, 32'(frame_tick), 32'd0);
    endtask

    task automatic random_run(input int cycles);
        int hold = 0;
        for (int c = 0; c < cycles; c++) begin
            if (hold == 0) begin
                emerg = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 45);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) Disp_1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) Disp_2 = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    initial begin
        reset  = 1'b0;
        emerg  = 1'b0;
        Disp_1 = 4'd3;
        Disp_2 = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");

        reset = 1'b1;
        k = 0;
        for (int c = 0; c < 40; c++) step();
        // Zero digits exercise the leading-digit path
        Disp_2 = 4'd0;
        for (int c = 0; c < 40; c++) step();
        random_run(700);

        // Reset asynchronously during DIG1 while blinking
        emerg = 1'b1;
        for (int c = 0; c < 30; c++) step();
        for (int c = 0; c < 32 && ((k % (4*R)) != 6); c++) step();
        #3 reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");

        reset = 1'b1;
        k = 0;
        random_run(600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
